// File: rtl/apu_pkg.sv
// Shared definitions for the APU instruction sequencer: opcodes, instruction
// field positions and the sequencer state encoding.
package apu_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 28;
  localparam int CONV_MSB = 27;
  localparam int CONV_LSB = 22;
  localparam int BN_MSB   = 21;
  localparam int BN_LSB   = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 0;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_LAYER      = 4'h1;
  localparam logic [3:0] OP_WAIT       = 4'h2;
  localparam logic [3:0] OP_LAYER_WAIT = 4'h3;
  localparam logic [3:0] OP_END        = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/apu_ir_decode.sv
// Combinational instruction splitter: breaks an IR word into its fields and
// flags whether the opcode is one the sequencer understands.
module apu_ir_decode
  import apu_pkg::*;
(
  input  logic [31:0] ir_word,
  output logic [3:0]  opcode,
  output logic [5:0]  conv_sel,
  output logic [5:0]  bn_sel,
  output logic [15:0] len,
  output logic        is_legal
);

  assign opcode   = ir_word[OPC_MSB:OPC_LSB];
  assign conv_sel = ir_word[CONV_MSB:CONV_LSB];
  assign bn_sel   = ir_word[BN_MSB:BN_LSB];
  assign len      = ir_word[LEN_MSB:LEN_LSB];

  always_comb begin
    case (opcode)
      OP_NOP, OP_LAYER, OP_WAIT, OP_LAYER_WAIT, OP_END: is_legal = 1'b1;
      default:                                          is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/apu_ir_sequencer.sv
// APU instruction sequencer: fetches IR words after a host start pulse, issues
// layer commands over valid/ready, waits on engine completion and reports done.
module apu_ir_sequencer
  import apu_pkg::*;
#(
  parameter int IR_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     apu_ready,
  input  logic                     abort,
  output logic                     ir_ram_ren,
  output logic [IR_DEPTH_LOG2-1:0] ir_ram_raddr,
  input  logic [31:0]              ir_ram_rdata,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [5:0]               cmd_conv_sel,
  output logic [5:0]               cmd_bn_sel,
  output logic [15:0]              cmd_len,
  input  logic                     engine_done,
  output logic                     cal_cpl,
  output logic                     busy,
  output logic                     err
);

  seq_state_e state, state_nxt;

  logic [IR_DEPTH_LOG2-1:0] pc;
  logic [IR_DEPTH_LOG2-1:0] pc_one;
  logic                     pc_last;
  logic                     done_seen;
  logic                     pend_wait;

  logic                     accept;
  logic                     advance;
  logic                     pc_inc;
  logic                     set_err;
  logic                     consume_done;
  logic                     latch_cmd;

  logic                     cmd_valid_d;
  logic                     cal_cpl_d;
  logic                     busy_d;

  logic [3:0]               dec_opcode;
  logic [5:0]               dec_conv;
  logic [5:0]               dec_bn;
  logic [15:0]              dec_len;
  logic                     dec_legal;

  apu_ir_decode u_decode (
    .ir_word  (ir_ram_rdata),
    .opcode   (dec_opcode),
    .conv_sel (dec_conv),
    .bn_sel   (dec_bn),
    .len      (dec_len),
    .is_legal (dec_legal)
  );

  assign pc_one  = {{(IR_DEPTH_LOG2-1){1'b0}}, 1'b1};
  assign pc_last = (pc == {IR_DEPTH_LOG2{1'b1}});
  assign accept  = (state == ST_IDLE) && apu_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    advance      = 1'b0;
    pc_inc       = 1'b0;
    set_err      = 1'b0;
    consume_done = 1'b0;
    latch_cmd    = 1'b0;

    case (state)
      ST_IDLE:   if (apu_ready) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!dec_legal) begin
          set_err   = 1'b1;
          state_nxt = ST_FINISH;
        end else begin
          case (dec_opcode)
            OP_NOP:                  advance = 1'b1;
            OP_LAYER, OP_LAYER_WAIT: begin
              latch_cmd = 1'b1;
              state_nxt = ST_ISSUE;
            end
            OP_WAIT:                 state_nxt = ST_WAIT_DONE;
            default:                 state_nxt = ST_FINISH;
          endcase
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          if (pend_wait) state_nxt = ST_WAIT_DONE;
          else           advance   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (done_seen) begin
          consume_done = 1'b1;
          advance      = 1'b1;
        end
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase

    // Running off the end of the IR without an END is a program error.
    if (advance) begin
      if (pc_last) begin
        set_err   = 1'b1;
        state_nxt = ST_FINISH;
      end else begin
        pc_inc    = 1'b1;
        state_nxt = ST_FETCH;
      end
    end

    // Abort overrides everything; FINISH is already completing, so it just exits.
    if (abort && (state != ST_IDLE)) begin
      set_err      = 1'b1;
      pc_inc       = 1'b0;
      latch_cmd    = 1'b0;
      consume_done = 1'b0;
      state_nxt    = (state == ST_FINISH) ? ST_IDLE : ST_FINISH;
    end
  end

  always_comb begin
    ir_ram_ren   = (state == ST_FETCH);
    ir_ram_raddr = pc;
    cmd_valid_d  = (state_nxt == ST_ISSUE);
    cal_cpl_d    = (state_nxt == ST_FINISH);
    busy_d       = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_valid <= 1'b0;
      cal_cpl   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_valid <= cmd_valid_d;
      cal_cpl   <= cal_cpl_d;
      busy      <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc           <= '0;
      err          <= 1'b0;
      done_seen    <= 1'b0;
      pend_wait    <= 1'b0;
      cmd_conv_sel <= '0;
      cmd_bn_sel   <= '0;
      cmd_len      <= '0;
    end else begin
      if (accept)      pc <= '0;
      else if (pc_inc) pc <= pc + pc_one;

      if (accept)       err <= 1'b0;
      else if (set_err) err <= 1'b1;

      // A fresh done pulse wins over consumption so back-to-back pulses survive.
      if (accept)                                  done_seen <= 1'b0;
      else if ((state != ST_IDLE) && engine_done)  done_seen <= 1'b1;
      else if (consume_done)                       done_seen <= 1'b0;

      if (latch_cmd) begin
        pend_wait    <= (dec_opcode == OP_LAYER_WAIT);
        cmd_conv_sel <= dec_conv;
        cmd_bn_sel   <= dec_bn;
        cmd_len      <= dec_len;
      end
    end
  end

endmodule
